// File: rtl/ad_capture_sched.sv
// Capture scheduler for the dual-channel ADC front end: synchronises hsync/vsync,
// times the per-line sample strobes and divided ADC clock, and tracks line/frame position.
module ad_capture_sched #(
  parameter int unsigned DIV_W = 5,
  parameter int unsigned DLY_W = 32,
  parameter int unsigned SPL_W = 12,
  parameter int unsigned LPF_W = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable_i,
  input  logic             ext_hsync_i,
  input  logic             ext_vsync_i,
  input  logic [DIV_W-1:0] sample_clock_i,
  input  logic [DLY_W-1:0] delay_count_i,
  input  logic [SPL_W-1:0] samples_per_line_i,
  input  logic [LPF_W-1:0] lines_per_frame_i,
  output logic             ad_clk_o,
  output logic             sample_en_o,
  output logic             line_start_o,
  output logic             frame_start_o,
  output logic             frame_done_o,
  output logic [SPL_W-1:0] sample_idx_o,
  output logic [LPF_W-1:0] line_idx_o,
  output logic             busy_o,
  output logic             overrun_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_VS = 3'd1,
    WAIT_HS = 3'd2,
    DELAY   = 3'd3,
    SAMPLE  = 3'd4
  } state_t;

  state_t           state_r, state_n, cur_s;
  logic [2:0]       hs_sync_r, vs_sync_r;
  logic             hs_event_s, vs_event_s;
  logic [DIV_W-1:0] div_r, div_n, phase_r, phase_n, half_s;
  logic [DLY_W-1:0] dly_cfg_r, dly_cfg_n, dly_cnt_r, dly_cnt_n;
  logic [SPL_W-1:0] spl_r, spl_n, sample_idx_r, sample_idx_n;
  logic [LPF_W-1:0] lpf_r, lpf_n, line_idx_r, line_idx_n, lpf_eff_s;
  logic [SPL_W:0]   strobe_cnt_s;
  logic             overrun_r, overrun_n, line_end_s;
  logic             line_start_n, frame_start_n, frame_done_n;
  logic             ad_clk_r, sample_en_r, line_start_r, frame_start_r, frame_done_r, busy_r;

  // Events fire on the rising (release) edge of the synchronised active-low syncs.
  assign hs_event_s = hs_sync_r[1] & ~hs_sync_r[2];
  assign vs_event_s = vs_sync_r[1] & ~vs_sync_r[2];
  assign lpf_eff_s  = (lpf_r == '0) ? {{(LPF_W-1){1'b0}}, 1'b1} : lpf_r;
  assign half_s     = DIV_W'(({1'b0, div_r} + (DIV_W+1)'(2)) >> 1);

  // Two-flop synchronisers plus the previous-value flop for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_sync_r <= 3'b111;
      vs_sync_r <= 3'b111;
    end else begin
      hs_sync_r <= {hs_sync_r[1:0], ext_hsync_i};
      vs_sync_r <= {vs_sync_r[1:0], ext_vsync_i};
    end
  end

  // Next-state logic: a frame event is applied first so a coincident line event sees the new frame.
  always_comb begin
    state_n       = state_r;
    cur_s         = state_r;
    div_n         = div_r;
    dly_cfg_n     = dly_cfg_r;
    spl_n         = spl_r;
    lpf_n         = lpf_r;
    dly_cnt_n     = dly_cnt_r;
    phase_n       = phase_r;
    sample_idx_n  = sample_idx_r;
    line_idx_n    = line_idx_r;
    overrun_n     = overrun_r;
    line_start_n  = 1'b0;
    frame_start_n = 1'b0;
    frame_done_n  = 1'b0;
    line_end_s    = 1'b0;
    strobe_cnt_s  = {1'b0, sample_idx_r} + {{SPL_W{1'b0}}, (phase_r == '0)};
    if (!enable_i) begin
      state_n   = IDLE;
      overrun_n = 1'b0;
    end else if (state_r == IDLE) begin
      state_n = WAIT_VS;
    end else begin
      if (vs_event_s) begin
        frame_start_n = 1'b1;
        line_idx_n    = '0;
        cur_s         = WAIT_HS;
        state_n       = WAIT_HS;
        div_n         = sample_clock_i;
        dly_cfg_n     = delay_count_i;
        spl_n         = samples_per_line_i;
        lpf_n         = lines_per_frame_i;
      end else begin
        cur_s = state_r;
      end
      if (hs_event_s && (cur_s != WAIT_VS)) begin
        if ((cur_s == DELAY) || (cur_s == SAMPLE)) begin
          overrun_n  = 1'b1;
          line_idx_n = line_idx_r + 1'b1;
        end else begin
          overrun_n  = overrun_r;
        end
        line_start_n = 1'b1;
        dly_cnt_n    = dly_cfg_n;
        sample_idx_n = '0;
        phase_n      = '0;
        state_n      = DELAY;
      end else begin
        case (cur_s)
          DELAY: begin
            if (dly_cnt_r != '0) begin
              dly_cnt_n = dly_cnt_r - 1'b1;
            end else if (spl_r == '0) begin
              line_end_s = 1'b1;
            end else begin
              state_n = SAMPLE;
              phase_n = '0;
            end
          end
          SAMPLE: begin
            if (phase_r == '0) begin
              sample_idx_n = sample_idx_r + 1'b1;
            end else begin
              sample_idx_n = sample_idx_r;
            end
            if (phase_r == div_r) begin
              phase_n    = '0;
              line_end_s = (strobe_cnt_s >= {1'b0, spl_r});
            end else begin
              phase_n = phase_r + 1'b1;
            end
          end
          default: line_end_s = 1'b0;
        endcase
      end
      if (line_end_s) begin
        line_idx_n = line_idx_r + 1'b1;
        if (({1'b0, line_idx_r} + 1'b1) >= {1'b0, lpf_eff_s}) begin
          frame_done_n = 1'b1;
          state_n      = WAIT_VS;
        end else begin
          state_n      = WAIT_HS;
        end
      end else begin
        line_idx_n = line_idx_n;
      end
    end
  end

  // State, counters, latched configuration and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= IDLE;
      div_r         <= '0;
      dly_cfg_r     <= '0;
      spl_r         <= '0;
      lpf_r         <= '0;
      dly_cnt_r     <= '0;
      phase_r       <= '0;
      sample_idx_r  <= '0;
      line_idx_r    <= '0;
      overrun_r     <= 1'b0;
      ad_clk_r      <= 1'b0;
      sample_en_r   <= 1'b0;
      line_start_r  <= 1'b0;
      frame_start_r <= 1'b0;
      frame_done_r  <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      state_r       <= state_n;
      div_r         <= div_n;
      dly_cfg_r     <= dly_cfg_n;
      spl_r         <= spl_n;
      lpf_r         <= lpf_n;
      dly_cnt_r     <= dly_cnt_n;
      phase_r       <= phase_n;
      sample_idx_r  <= sample_idx_n;
      line_idx_r    <= line_idx_n;
      overrun_r     <= overrun_n;
      ad_clk_r      <= (state_n == SAMPLE) && (phase_n < half_s);
      sample_en_r   <= (state_n == SAMPLE) && (phase_n == '0);
      line_start_r  <= line_start_n;
      frame_start_r <= frame_start_n;
      frame_done_r  <= frame_done_n;
      busy_r        <= (state_n == DELAY) || (state_n == SAMPLE);
    end
  end

  assign ad_clk_o      = ad_clk_r;
  assign sample_en_o   = sample_en_r;
  assign line_start_o  = line_start_r;
  assign frame_start_o = frame_start_r;
  assign frame_done_o  = frame_done_r;
  assign sample_idx_o  = sample_idx_r;
  assign line_idx_o    = line_idx_r;
  assign busy_o        = busy_r;
  assign overrun_o     = overrun_r;

endmodule

// File: tb/tb_ad_capture_sched.sv
// Self-checking bench for ad_capture_sched: constant-expectation table, randomized
// frames against an arithmetic timing model, and hand-written corner sequences.
module tb_ad_capture_sched;
  localparam int DIV_W = 5;
  localparam int DLY_W = 32;
  localparam int SPL_W = 12;
  localparam int LPF_W = 10;

  logic clk = 1'b0;
  logic reset_n, enable_i, ext_hsync_i, ext_vsync_i;
  logic [DIV_W-1:0] sample_clock_i;
  logic [DLY_W-1:0] delay_count_i;
  logic [SPL_W-1:0] samples_per_line_i;
  logic [LPF_W-1:0] lines_per_frame_i;
  logic ad_clk_o, sample_en_o, line_start_o, frame_start_o, frame_done_o, busy_o, overrun_o;
  logic [SPL_W-1:0] sample_idx_o;
  logic [LPF_W-1:0] line_idx_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ad_capture_sched #(.DIV_W(DIV_W), .DLY_W(DLY_W), .SPL_W(SPL_W), .LPF_W(LPF_W)) dut (
    .clk(clk), .reset_n(reset_n), .enable_i(enable_i),
    .ext_hsync_i(ext_hsync_i), .ext_vsync_i(ext_vsync_i),
    .sample_clock_i(sample_clock_i), .delay_count_i(delay_count_i),
    .samples_per_line_i(samples_per_line_i), .lines_per_frame_i(lines_per_frame_i),
    .ad_clk_o(ad_clk_o), .sample_en_o(sample_en_o), .line_start_o(line_start_o),
    .frame_start_o(frame_start_o), .frame_done_o(frame_done_o),
    .sample_idx_o(sample_idx_o), .line_idx_o(line_idx_o),
    .busy_o(busy_o), .overrun_o(overrun_o)
  );

  typedef struct {
    int div; int dly; int spl; int lpf;
    int first; int nstrb; int adhi; int len;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_cfg(input int div, input int dly, input int spl, input int lpf);
    sample_clock_i     = div[DIV_W-1:0];
    delay_count_i      = dly[DLY_W-1:0];
    samples_per_line_i = spl[SPL_W-1:0];
    lines_per_frame_i  = lpf[LPF_W-1:0];
  endtask

  // Active-low pulse of two clocks; returns at the negedge where the inputs rise.
  task automatic pulse(input bit h, input bit v);
    if (h) ext_hsync_i = 1'b0;
    if (v) ext_vsync_i = 1'b0;
    repeat (2) @(negedge clk);
    ext_hsync_i = 1'b1;
    ext_vsync_i = 1'b1;
  endtask

  task automatic wait_for(input bit frame, input string name);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (frame ? frame_start_o : line_start_o) return;
    end
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected pulse", name);
  endtask

  // Starts at the line_start cycle; returns at the first cycle where busy is low.
  task automatic measure_line(input int div, input int dly, input int spl, input bit use_model,
                              output int first, output int nstrb, output int adhi, output int len);
    int s0, p, elen, off, eidx;
    logic exp_en, exp_ad, exp_busy;
    s0 = dly + 1;
    p = div + 1;
    elen = s0 + spl * p;
    first = -1; nstrb = 0; adhi = 0; len = -1;
    for (int t = 0; t < 3000; t++) begin
      if (t > 0) @(negedge clk);
      if (!busy_o) begin
        len = t;
        break;
      end
      if (sample_en_o) begin
        if (first < 0) first = t;
        nstrb++;
      end
      if (ad_clk_o) adhi++;
      if (use_model) begin
        off = t - s0;
        exp_busy = (t < elen);
        exp_en = (t >= s0) && (t < elen) && (off % p == 0);
        exp_ad = (t >= s0) && (t < elen) && (off % p < (div + 2) / 2);
        check("line_cycle", {sample_en_o, ad_clk_o, busy_o}, {exp_en, exp_ad, exp_busy});
        if ((t >= s0) && (t < elen)) begin
          eidx = off / p + ((off % p != 0) ? 1 : 0);
          check("sample_idx", sample_idx_o, eidx);
        end
      end
    end
    if (len < 0) check("line_timeout", 1, 0);
  endtask

  initial begin
    vec_t tbl[6];
    int first, nstrb, adhi, len, cnt, div, dly, spl, lpf, lpe;
    logic [SPL_W-1:0] held_sidx;
    logic [LPF_W-1:0] held_lidx;

    tbl[0] = '{3, 10, 8, 1, 11, 8, 16, 43};
    tbl[1] = '{0, 0, 5, 1, 1, 5, 5, 6};
    tbl[2] = '{1, 2, 3, 1, 3, 3, 3, 9};
    tbl[3] = '{4, 0, 2, 1, 1, 2, 6, 11};
    tbl[4] = '{2, 5, 0, 0, -1, 0, 0, 6};
    tbl[5] = '{31, 1, 2, 1, 2, 2, 32, 66};

    reset_n = 1'b0; enable_i = 1'b1; ext_hsync_i = 1'b1; ext_vsync_i = 1'b1;
    set_cfg(0, 0, 0, 0);
    repeat (3) tick();
    check("reset_pulses", {ad_clk_o, sample_en_o, line_start_o, frame_start_o,
                           frame_done_o, busy_o, overrun_o}, 0);
    check("reset_idx", {sample_idx_o, line_idx_o}, 0);
    reset_n = 1'b1;
    repeat (2) tick();

    // Basic line with sync latency, then frame end.
    set_cfg(3, 10, 8, 2);
    pulse(1'b0, 1'b1);
    repeat (2) begin tick(); check("fs_early", frame_start_o, 0); end
    tick(); check("fs_latency", frame_start_o, 1);
    check("fs_line_idx", line_idx_o, 0);
    pulse(1'b1, 1'b0);
    repeat (2) begin tick(); check("ls_early", line_start_o, 0); end
    tick(); check("ls_latency", line_start_o, 1);
    measure_line(3, 10, 8, 1'b1, first, nstrb, adhi, len);
    check("basic_first", first, 11);
    check("basic_nstrb", nstrb, 8);
    check("basic_adhi", adhi, 16);
    check("basic_len", len, 43);
    check("basic_line_idx", line_idx_o, 1);
    check("basic_no_done", frame_done_o, 0);
    pulse(1'b1, 1'b0);
    wait_for(1'b0, "ls2_wait");
    measure_line(3, 10, 8, 1'b1, first, nstrb, adhi, len);
    check("end_nstrb", nstrb, 8);
    check("end_done", frame_done_o, 1);
    check("end_line_idx", line_idx_o, 2);
    tick(); check("end_done_once", frame_done_o, 0);
    pulse(1'b1, 1'b0);
    cnt = 0;
    repeat (6) begin tick(); if (line_start_o || busy_o) cnt++; end
    check("hs_ignored_wait_vs", cnt, 0);

    // Table of single-line frames with hand-computed timing.
    for (int i = 0; i < 6; i++) begin
      set_cfg(tbl[i].div, tbl[i].dly, tbl[i].spl, tbl[i].lpf);
      pulse(1'b0, 1'b1);
      wait_for(1'b1, "tbl_fs");
      pulse(1'b1, 1'b0);
      wait_for(1'b0, "tbl_ls");
      measure_line(tbl[i].div, tbl[i].dly, tbl[i].spl, 1'b0, first, nstrb, adhi, len);
      check("tbl_first", first, tbl[i].first);
      check("tbl_nstrb", nstrb, tbl[i].nstrb);
      check("tbl_adhi", adhi, tbl[i].adhi);
      check("tbl_len", len, tbl[i].len);
      check("tbl_done", frame_done_o, 1);
      check("tbl_line_idx", line_idx_o, 1);
    end

    // Random frames against the timing model.
    for (int it = 0; it < 8; it++) begin
      div = $urandom_range(0, 4); dly = $urandom_range(0, 5);
      spl = $urandom_range(0, 6); lpf = $urandom_range(0, 3);
      lpe = (lpf == 0) ? 1 : lpf;
      set_cfg(div, dly, spl, lpf);
      pulse(1'b0, 1'b1);
      wait_for(1'b1, "rnd_fs");
      check("rnd_fs_line_idx", line_idx_o, 0);
      for (int l = 0; l < lpe; l++) begin
        pulse(1'b1, 1'b0);
        wait_for(1'b0, "rnd_ls");
        measure_line(div, dly, spl, 1'b1, first, nstrb, adhi, len);
        check("rnd_len", len, dly + 1 + spl * (div + 1));
        check("rnd_line_idx", line_idx_o, l + 1);
        check("rnd_done", frame_done_o, (l + 1 == lpe) ? 1 : 0);
      end
    end

    // Overrun: second hsync after 20 strobes of a long line.
    set_cfg(3, 0, 100, 5);
    pulse(1'b0, 1'b1);
    wait_for(1'b1, "ovr_fs");
    pulse(1'b1, 1'b0);
    wait_for(1'b0, "ovr_ls");
    cnt = 0;
    for (int t = 0; t < 200 && cnt < 20; t++) begin
      tick();
      if (sample_en_o) cnt++;
    end
    check("ovr_strobes", cnt, 20);
    check("ovr_before", overrun_o, 0);
    pulse(1'b1, 1'b0);
    wait_for(1'b0, "ovr_ls2");
    check("ovr_flag", overrun_o, 1);
    check("ovr_line_idx", line_idx_o, 1);
    check("ovr_sample_idx", sample_idx_o, 0);

    // vsync mid-line, then vsync and hsync together mid-line.
    repeat (5) tick();
    pulse(1'b0, 1'b1);
    wait_for(1'b1, "vs_mid_fs");
    check("vs_mid_state", {line_idx_o, line_start_o, busy_o, frame_done_o}, 0);
    pulse(1'b1, 1'b0);
    wait_for(1'b0, "vs_mid_ls");
    repeat (6) tick();
    pulse(1'b1, 1'b1);
    wait_for(1'b1, "both_fs");
    check("both_ls", line_start_o, 1);
    check("both_line_idx", line_idx_o, 0);
    check("both_busy", busy_o, 1);

    // enable_i dropped mid-SAMPLE.
    repeat (5) tick();
    held_sidx = sample_idx_o;
    held_lidx = line_idx_o;
    enable_i = 1'b0;
    tick();
    check("en_off_outs", {busy_o, ad_clk_o, sample_en_o, overrun_o, line_start_o}, 0);
    check("en_off_idx", {sample_idx_o, line_idx_o}, {held_sidx, held_lidx});
    tick();
    check("en_off_adclk", ad_clk_o, 0);
    enable_i = 1'b1;
    repeat (2) tick();

    // Asynchronous reset mid-SAMPLE with ad_clk held high.
    set_cfg(0, 0, 100, 1);
    pulse(1'b0, 1'b1);
    wait_for(1'b1, "rst_fs");
    pulse(1'b1, 1'b0);
    wait_for(1'b0, "rst_ls");
    repeat (3) tick();
    check("rst_pre", {ad_clk_o, sample_en_o, busy_o}, 3'b111);
    #2 reset_n = 1'b0;
    #1 check("rst_async", {ad_clk_o, sample_en_o, line_start_o, frame_start_o,
                           frame_done_o, busy_o, overrun_o, sample_idx_o, line_idx_o}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
